// File: rtl/cfu_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cfu_conv_sequencer
// Description : Replays a complete convolution job into a CFU over the
//               cmd/rsp protocol.  The job is filter load, input load, layer
//               parameters, then per output point: clear, point parameters,
//               accumulate and return one 32-bit accumulator.  Operands come
//               from a 64-bit word stream.  Only one command is ever in
//               flight, and a watchdog bounds every response wait.
// Revision    : 1.0 - initial release
// ============================================================================
module cfu_conv_sequencer #(
  parameter int CNT_W          = 16,
  parameter int OUT_CNT_W      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // job control
  input  logic                 start,
  input  logic [CNT_W-1:0]     filter_beats,
  input  logic [CNT_W-1:0]     input_beats,
  input  logic [OUT_CNT_W-1:0] n_outputs,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  // operand word stream
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [31:0]          data_0,
  input  logic [31:0]          data_1,
  // CFU command channel
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [9:0]           cmd_payload_function_id,
  output logic [31:0]          cmd_payload_inputs_0,
  output logic [31:0]          cmd_payload_inputs_1,
  // CFU response channel
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [31:0]          rsp_payload_outputs_0,
  // per-point result channel
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [OUT_CNT_W-1:0] res_index
);

  // Control states: every command goes ISSUE -> SEND -> WAIT_RSP.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_RES      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Job phase selects which CFU function the next command carries.
  typedef enum logic [3:0] {
    P_CLR_F    = 4'd0,
    P_LD_F     = 4'd1,
    P_CLR_I    = 4'd2,
    P_LD_I     = 4'd3,
    P_PRM_RST  = 4'd4,
    P_PRM      = 4'd5,
    P_OUT_CLR  = 4'd6,
    P_OUT_PRM  = 4'd7,
    P_ACC      = 4'd8
  } phase_t;

  localparam logic [31:0]    c_timeout      = 32'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_layer_prms = CNT_W'(6);
  localparam logic [CNT_W-1:0] c_point_prms = CNT_W'(3);

  state_t                 r_state;
  phase_t                 r_phase;
  logic [CNT_W-1:0]       r_filter_beats;
  logic [CNT_W-1:0]       r_input_beats;
  logic [OUT_CNT_W-1:0]   r_n_outputs;
  logic [CNT_W-1:0]       r_beat_cnt;
  logic [OUT_CNT_W-1:0]   r_point;
  logic [31:0]            r_wd_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_cmd_valid;
  logic [9:0]             r_func;
  logic [31:0]            r_in0;
  logic [31:0]            r_in1;
  logic                   r_rsp_ready;
  logic                   r_res_valid;
  logic [31:0]            r_res_data;
  logic [OUT_CNT_W-1:0]   r_res_index;

  logic [6:0]             w_f7;
  logic                   w_has_data;
  logic                   w_capture;
  logic                   w_wd_hit;
  phase_t                 w_next_phase;
  logic                   w_next_done;
  logic [OUT_CNT_W-1:0]   w_point_inc;

  // Function code and stream usage for the current phase.
  always_comb begin
    w_f7       = 7'd0;
    w_has_data = 1'b0;
    case (r_phase)
      P_CLR_F:   w_f7 = 7'd0;
      P_LD_F:    begin w_f7 = 7'd1;  w_has_data = 1'b1; end
      P_CLR_I:   w_f7 = 7'd3;
      P_LD_I:    begin w_f7 = 7'd4;  w_has_data = 1'b1; end
      P_PRM_RST: w_f7 = 7'd6;
      P_PRM:     begin w_f7 = 7'd7;  w_has_data = 1'b1; end
      P_OUT_CLR: w_f7 = 7'd8;
      P_OUT_PRM: begin w_f7 = 7'd9;  w_has_data = 1'b1; end
      P_ACC:     w_f7 = 7'd10;
      default:   w_f7 = 7'd0;
    endcase
  end

  // Phase sequencing after a non-accumulate response; zero counts skip phases.
  always_comb begin
    w_next_phase = r_phase;
    w_next_done  = 1'b0;
    case (r_phase)
      P_CLR_F:   w_next_phase = (r_filter_beats != '0) ? P_LD_F : P_CLR_I;
      P_LD_F:    w_next_phase = (r_beat_cnt == r_filter_beats) ? P_CLR_I : P_LD_F;
      P_CLR_I:   w_next_phase = (r_input_beats != '0) ? P_LD_I : P_PRM_RST;
      P_LD_I:    w_next_phase = (r_beat_cnt == r_input_beats) ? P_PRM_RST : P_LD_I;
      P_PRM_RST: w_next_phase = P_PRM;
      P_PRM: begin
        if (r_beat_cnt == c_layer_prms) begin
          if (r_n_outputs != '0) begin
            w_next_phase = P_OUT_CLR;
          end else begin
            w_next_done = 1'b1;
          end
        end
      end
      P_OUT_CLR: w_next_phase = P_OUT_PRM;
      P_OUT_PRM: w_next_phase = (r_beat_cnt == c_point_prms) ? P_ACC : P_OUT_PRM;
      default:   w_next_phase = r_phase;
    endcase
  end

  // A stream word is taken only while a data command waits for its operand.
  assign w_capture   = (r_state == S_ISSUE) && w_has_data && data_valid;
  // Watchdog fires on the cycle its count would reach the limit; 0 disables it.
  assign w_wd_hit    = (c_timeout != 32'd0) && ((r_wd_cnt + 32'd1) == c_timeout);
  assign w_point_inc = r_point + OUT_CNT_W'(1);

  // Main sequencer: job control, command issue, response and result handling.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_phase        <= P_CLR_F;
      r_filter_beats <= '0;
      r_input_beats  <= '0;
      r_n_outputs    <= '0;
      r_beat_cnt     <= '0;
      r_point        <= '0;
      r_wd_cnt       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_func         <= '0;
      r_in0          <= '0;
      r_in1          <= '0;
      r_rsp_ready    <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_index    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_filter_beats <= filter_beats;
            r_input_beats  <= input_beats;
            r_n_outputs    <= n_outputs;
            r_err          <= 1'b0;
            r_busy         <= 1'b1;
            r_phase        <= P_CLR_F;
            r_beat_cnt     <= '0;
            r_point        <= '0;
            r_state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Data commands wait here for a word; data-less ones go out at once.
          if (!w_has_data) begin
            r_in0       <= '0;
            r_in1       <= '0;
            r_func      <= {w_f7, 3'b000};
            r_cmd_valid <= 1'b1;
            r_state     <= S_SEND;
          end else if (w_capture) begin
            r_in0       <= data_0;
            r_in1       <= data_1;
            r_func      <= {w_f7, 3'b000};
            r_cmd_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
            r_wd_cnt    <= '0;
            // Accumulate holds off rsp_ready until the result is visible.
            r_rsp_ready <= (r_phase != P_ACC);
            r_state     <= S_WAIT_RSP;
          end
        end

        S_WAIT_RSP: begin
          if (rsp_valid && (r_phase == P_ACC)) begin
            r_res_data  <= rsp_payload_outputs_0;
            r_res_valid <= 1'b1;
            r_res_index <= r_point;
            r_rsp_ready <= 1'b1;
            r_state     <= S_RES;
          end else if (rsp_valid && r_rsp_ready) begin
            r_rsp_ready <= 1'b0;
            r_beat_cnt  <= (w_next_phase != r_phase) ? '0 : r_beat_cnt;
            if (w_next_done) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_phase <= w_next_phase;
              r_state <= S_ISSUE;
            end
          end else if (w_wd_hit) begin
            r_err       <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_wd_cnt != '1) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
          end
        end

        S_RES: begin
          // rsp_ready was raised for exactly the first cycle in this state.
          r_rsp_ready <= 1'b0;
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_point     <= w_point_inc;
            if (w_point_inc == r_n_outputs) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_phase    <= P_OUT_CLR;
              r_beat_cnt <= '0;
              r_state    <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy                    = r_busy;
  assign done                    = r_done;
  assign err                     = r_err;
  assign data_ready              = w_capture;
  assign cmd_valid               = r_cmd_valid;
  assign cmd_payload_function_id = r_func;
  assign cmd_payload_inputs_0    = r_in0;
  assign cmd_payload_inputs_1    = r_in1;
  assign rsp_ready               = r_rsp_ready;
  assign res_valid               = r_res_valid;
  assign res_data                = r_res_data;
  assign res_index               = r_res_index;

endmodule
`default_nettype wire

// File: tb/tb_cfu_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfu_conv_sequencer
// Description : Scoreboard bench for cfu_conv_sequencer with a CFU model,
//               a word-stream source and a result sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfu_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] filter_beats, input_beats, n_outputs;
  logic        busy, done, err;
  logic        data_valid, data_ready;
  logic [31:0] data_0, data_1;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [15:0] res_index;

  cfu_conv_sequencer #(.CNT_W(16), .OUT_CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .filter_beats(filter_beats), .input_beats(input_beats), .n_outputs(n_outputs),
    .busy(busy), .done(done), .err(err),
    .data_valid(data_valid), .data_ready(data_ready), .data_0(data_0), .data_1(data_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // scoreboard queues and stimulus state
  logic [73:0] exp_cmd[$];
  logic [47:0] exp_res[$];
  logic [63:0] word_q[$];
  logic [31:0] acc_q[$];
  int          word_seq = 0;
  int          words_used = 0;
  int          gap_at = 0, gap_left = 0;
  int          stall_left = 0;
  logic [6:0]  stall_f7 = 7'd0;
  int          hold_left = 0;
  logic [15:0] hold_idx = 16'd0;
  bit          no_acc_rsp = 0;
  bit          pend = 0;
  int          n_f4 = 0;
  int          acc_edge = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_data_f7(input logic [6:0] f7);
    return (f7 == 7'd1) || (f7 == 7'd4) || (f7 == 7'd7) || (f7 == 7'd9);
  endfunction

  task automatic push_cmd(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    exp_cmd.push_back({f7, 3'b000, a, b});
  endtask

  task automatic push_word(input logic [6:0] f7);
    logic [31:0] a, b;
    word_seq++;
    a = 32'hA000_0000 | 32'(word_seq);
    b = 32'hB000_0000 | 32'(word_seq);
    word_q.push_back({b, a});
    push_cmd(f7, a, b);
  endtask

  // Expected command order for one job, plus results and CFU accumulator values.
  task automatic plan_job(input int fb, input int ib, input int n, input logic [31:0] base,
                          input logic [31:0] step, input bit with_res, output int ndata);
    logic [31:0] v;
    ndata = 0;
    push_cmd(7'd0, 32'd0, 32'd0);
    for (int i = 0; i < fb; i++) begin push_word(7'd1); ndata++; end
    push_cmd(7'd3, 32'd0, 32'd0);
    for (int i = 0; i < ib; i++) begin push_word(7'd4); ndata++; end
    push_cmd(7'd6, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin push_word(7'd7); ndata++; end
    for (int p = 0; p < n; p++) begin
      push_cmd(7'd8, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin push_word(7'd9); ndata++; end
      push_cmd(7'd10, 32'd0, 32'd0);
      if (with_res) begin
        v = base + step * 32'(p);
        acc_q.push_back(v);
        exp_res.push_back({16'(p), v});
      end
    end
  endtask

  task automatic start_job(input int fb, input int ib, input int n);
    @(posedge clk); #1;
    filter_beats = 16'(fb); input_beats = 16'(ib); n_outputs = 16'(n);
    words_used = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 96'(busy), 96'd1);
  endtask

  task automatic wait_done(input int maxc, output int at_cyc, output logic e);
    at_cyc = -1;
    e = 1'bx;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin at_cyc = cyc; e = err; break; end
      @(negedge clk);
    end
    chk("done_seen", 96'(at_cyc >= 0), 96'd1);
  endtask

  task automatic run_job(input string tag, input int fb, input int ib, input int n,
                         input logic [31:0] base, input logic [31:0] step,
                         input bit with_res, input logic exp_err, output int done_cyc);
    int   nd;
    logic e;
    plan_job(fb, ib, n, base, step, with_res, nd);
    start_job(fb, ib, n);
    wait_done(600, done_cyc, e);
    chk({tag, "_err"}, 96'(e), 96'(exp_err));
    @(negedge clk);
    chk({tag, "_busy_clear"}, 96'(busy), 96'd0);
    chk({tag, "_cmd_left"}, 96'(exp_cmd.size()), 96'd0);
    chk({tag, "_res_left"}, 96'(exp_res.size()), 96'd0);
    chk({tag, "_words"}, 96'(words_used), 96'(nd));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 96'({busy, done, err, data_ready, cmd_valid, rsp_ready, res_valid}), 96'd0);
    chk({tag, "_cmd_payload"}, {22'd0, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, 96'd0);
    chk({tag, "_res"}, 96'({res_index, res_data}), 96'd0);
  endtask

  // Word-stream source with optional valid gap.
  always begin
    bit   d_fire;
    logic [63:0] w;
    @(negedge clk);
    d_fire = data_valid && data_ready && reset_n;
    @(posedge clk); #1;
    if (d_fire && word_q.size() > 0) begin w = word_q.pop_front(); words_used++; end
    if (gap_left > 0 && words_used >= gap_at) begin
      data_valid = 1'b0; gap_left--;
    end else if (word_q.size() > 0) begin
      w = word_q[0];
      data_valid = 1'b1; data_1 = w[63:32]; data_0 = w[31:0];
    end else begin
      data_valid = 1'b0;
    end
  end

  // CFU model: one response per command; accumulate answers after a delay.
  always begin
    bit c_fire, r_fire, saw_done, rst_seen;
    logic [6:0] c_f7, pend_f7;
    int lat;
    @(negedge clk);
    c_fire   = cmd_valid && cmd_ready && reset_n;
    c_f7     = cmd_payload_function_id[9:3];
    r_fire   = rsp_valid && rsp_ready;
    saw_done = done;
    rst_seen = !reset_n;
    @(posedge clk); #1;
    if (rst_seen || saw_done) begin
      pend = 0; rsp_valid = 1'b0; lat = 0;
    end else begin
      if (r_fire) begin rsp_valid = 1'b0; pend = 0; end
      if (c_fire) begin pend = 1; pend_f7 = c_f7; lat = (c_f7 == 7'd10) ? 3 : 0; end
      if (pend && !rsp_valid) begin
        if (pend_f7 != 7'd10) begin
          rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'hDEAD_0000 | 32'(cyc[15:0]);
        end else if (!no_acc_rsp) begin
          if (lat > 0) lat--;
          else begin
            rsp_valid = 1'b1;
            rsp_payload_outputs_0 = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hBAD0_BAD0;
          end
        end
      end
    end
    if (cmd_valid && cmd_payload_function_id[9:3] == stall_f7 && stall_left > 0) begin
      cmd_ready = 1'b0; stall_left--;
    end else begin
      cmd_ready = 1'b1;
    end
  end

  // Result sink with optional backpressure on one index.
  always begin
    @(posedge clk); #1;
    if (res_valid && res_index == hold_idx && hold_left > 0) begin
      res_ready = 1'b0; hold_left--;
    end else begin
      res_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks protocol rules.
  always begin
    bit          captured, prev_stall, prev_cv;
    logic [73:0] prev_pl, e, act;
    logic [47:0] er;
    logic [6:0]  f7;
    @(negedge clk);
    if (!reset_n) begin
      captured = 0; prev_stall = 0; prev_cv = 0;
    end else begin
      act = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
      f7  = cmd_payload_function_id[9:3];
      if (prev_stall) chk("cmd_stable", {21'd0, cmd_valid, act}, {21'd0, 1'b1, prev_pl});
      prev_stall = cmd_valid && !cmd_ready;
      prev_pl    = act;
      if (cmd_valid && !prev_cv) chk("one_in_flight", 96'(pend), 96'd0);
      if (cmd_valid && f7 == 7'd8) chk("no_clr_while_res", 96'(res_valid), 96'd0);
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", {22'd0, act}, 96'd0);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd", {22'd0, act}, {22'd0, e});
        end
        if (f7 == 7'd4) n_f4++;
        if (f7 == 7'd10) acc_edge = cyc + 1;
        if (is_data_f7(f7)) begin chk("cmd_has_word", 96'(captured), 96'd1); captured = 0; end
      end
      if (data_valid && data_ready) captured = 1;
      if (data_ready) chk("data_ready_needs_valid", 96'(data_valid), 96'd1);
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          chk("res_unexpected", 96'({res_index, res_data}), 96'd0);
        end else begin
          er = exp_res.pop_front();
          chk("res", 96'({res_index, res_data}), 96'(er));
        end
      end
      prev_cv = cmd_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   dc, nd;
    logic e;
    reset_n = 1'b0; start = 1'b0;
    filter_beats = '0; input_beats = '0; n_outputs = '0;
    data_valid = 1'b0; data_0 = '0; data_1 = '0;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // T1: basic job, 17 commands, one result
    run_job("t1", 2, 1, 1, 32'h1234_5678, 32'd0, 1, 1'b0, dc);

    // T2: stream gap in the middle of the filter load
    gap_at = 2; gap_left = 5;
    run_job("t2", 4, 2, 1, 32'h0000_0ABC, 32'd0, 1, 1'b0, dc);

    // T3: CFU stalls the first input-load command for 3 cycles
    stall_f7 = 7'd4; stall_left = 3;
    run_job("t3", 1, 2, 1, 32'h0000_5555, 32'd0, 1, 1'b0, dc);
    chk("t3_stall_used", 96'(stall_left), 96'd0);

    // T4: three points, result sink stalls on the second one
    hold_idx = 16'd1; hold_left = 4;
    run_job("t4", 1, 1, 3, 32'd10, 32'd10, 1, 1'b0, dc);
    chk("t4_hold_used", 96'(hold_left), 96'd0);

    // T5: accumulate never answered -> watchdog
    no_acc_rsp = 1;
    run_job("t5", 0, 0, 1, 32'd0, 32'd0, 0, 1'b1, dc);
    chk("t5_timeout_latency", 96'(dc - acc_edge), 96'd16);
    no_acc_rsp = 0;
    chk("t5_err_sticky", 96'(err), 96'd1);

    // T6: reset in the middle of the input load, then an all-zero job
    n_f4 = 0;
    plan_job(2, 3, 1, 32'h77, 32'd0, 1, nd);
    start_job(2, 3, 1);
    chk("t6_err_cleared", 96'(err), 96'd0);
    for (int i = 0; i < 300 && n_f4 == 0; i++) @(negedge clk);
    chk("t6_reached_ld_i", 96'(n_f4 > 0), 96'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("t6_reset");
    exp_cmd.delete(); exp_res.delete(); word_q.delete(); acc_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    run_job("t6", 0, 0, 0, 32'd0, 32'd0, 0, 1'b0, dc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
